// File: rtl/piece_color_pipe.sv
// piece_color_pipe: maps a shape index plus occupancy bit to a pixel colour.
// Two-stage pipeline with a valid flag. The palette is run-time programmable
// and comes up with the classic tetromino colours. A free-running blink timer
// flashes cells in rows that are being cleared.
module piece_color_pipe #(
    parameter int SHAPE_W    = 3,
    parameter int COLOR_W    = 3,
    parameter int NUM_SHAPES = 7,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Enable,
    input  logic [SHAPE_W-1:0] Shape,
    input  logic               MSB,
    input  logic               Flash,
    input  logic               WrEn,
    input  logic [SHAPE_W-1:0] WrAddr,
    input  logic [COLOR_W-1:0] WrData,
    output logic [COLOR_W-1:0] Color,
    output logic               ColorValid
);

    localparam int STAGES = 2;
    localparam int CNT_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [SHAPE_W:0]   NS       = (SHAPE_W + 1)'(NUM_SHAPES);

    // Stage-1 sample captured from the board readout.
    typedef struct packed {
        logic [SHAPE_W-1:0] shape;
        logic               msb;
        logic               flash;
    } samp_t;

    // Reset-default palette. Colours are R,G,B and are zero-extended for
    // wider colour words. Entries past the seventh shape have no default.
    function automatic logic [COLOR_W-1:0] dflt_color(input int idx);
        logic [2:0] c;
        case (idx)
            0:       c = 3'b011;  // I
            1:       c = 3'b110;  // O
            2:       c = 3'b010;  // S
            3:       c = 3'b001;  // J
            4:       c = 3'b101;  // T
            5:       c = 3'b100;  // Z
            6:       c = 3'b111;  // L
            default: c = 3'b000;
        endcase
        return COLOR_W'(c);
    endfunction

    logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
    samp_t              s1_q, s1_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [COLOR_W-1:0] pal_q [NUM_SHAPES];
    logic [COLOR_W-1:0] pal_d [NUM_SHAPES];
    logic [COLOR_W-1:0] pal_rd;

    // Blink timer: wraps at BLINK_DIV-1 and toggles the phase on the wrap edge.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Palette update. Addresses past the last real entry match nothing, so
    // they are dropped without any extra range check.
    always_comb begin
        for (int i = 0; i < NUM_SHAPES; i++) begin
            pal_d[i] = pal_q[i];
            if (WrEn && (WrAddr == SHAPE_W'(i)))
                pal_d[i] = WrData;
        end
    end

    // Palette read for the stage-1 shape. Registered palette gives
    // read-before-write on a same-edge write to the same entry.
    always_comb begin
        pal_rd = '0;
        for (int i = 0; i < NUM_SHAPES; i++) begin
            if (s1_q.shape == SHAPE_W'(i))
                pal_rd = pal_q[i];
        end
    end

    // Stage 1: capture the sample. When Enable is low only the valid bit
    // drops and the data fields simply hold.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], Enable};
        s1_d       = s1_q;
        if (Enable) begin
            s1_d.shape = Shape;
            s1_d.msb   = MSB;
            s1_d.flash = Flash;
        end
    end

    // Stage 2: colour resolution in priority order. The blink phase is the
    // value held before this edge, not the value toggled on it.
    always_comb begin
        color_d = color_q;
        if (vld_pipe_q[1]) begin
            if (!s1_q.msb)
                color_d = '0;
            else if ({1'b0, s1_q.shape} >= NS)
                color_d = '0;
            else if (s1_q.flash && phase_q)
                color_d = '1;
            else
                color_d = pal_rd;
        end
    end

    // All state: pipeline, blink timer and palette share one async reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            color_q    <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            for (int i = 0; i < NUM_SHAPES; i++)
                pal_q[i] <= dflt_color(i);
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            color_q    <= color_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            for (int i = 0; i < NUM_SHAPES; i++)
                pal_q[i] <= pal_d[i];
        end
    end

    assign Color      = color_q;
    assign ColorValid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_piece_color_pipe.sv
// Scoreboard bench for piece_color_pipe with a short blink period.
module tb_piece_color_pipe;

    localparam int BDIV = 4;

    logic       Clock, Resetn, Enable, MSB, Flash, WrEn;
    logic [2:0] Shape, WrAddr, WrData, Color;
    logic       ColorValid;

    piece_color_pipe #(.SHAPE_W(3), .COLOR_W(3), .NUM_SHAPES(7), .BLINK_DIV(BDIV)) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Shape(Shape),
        .MSB(MSB), .Flash(Flash), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .Color(Color), .ColorValid(ColorValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       v;
        logic [2:0] c;
    } exp_t;

    exp_t       sbq[$];
    logic [2:0] pal [7];
    logic [2:0] last_c;
    int         ecount;
    int         n_chk = 0;
    int         n_err = 0;

    // Edges seen since reset release; drives the blink-phase model.
    always @(posedge Clock or negedge Resetn)
        if (!Resetn) ecount <= 0;
        else         ecount <= ecount + 1;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pal[0] = 3'b011; pal[1] = 3'b110; pal[2] = 3'b010; pal[3] = 3'b001;
        pal[4] = 3'b101; pal[5] = 3'b100; pal[6] = 3'b111;
        last_c = 3'b000;
        sbq.delete();
        sbq.push_back('{1'b0, 3'b000});
        sbq.push_back('{1'b0, 3'b000});
    endtask

    // One cycle: check the output due now, drive new inputs, push expectation.
    task automatic step(input logic en, input logic [2:0] sh, input logic m, input logic f,
                        input logic we, input logic [2:0] wa, input logic [2:0] wd);
        exp_t e, n;
        logic ph;
        @(negedge Clock);
        e = sbq.pop_front();
        chk("valid", {7'b0, ColorValid}, {7'b0, e.v});
        chk("color", {5'b0, Color}, {5'b0, e.c});
        Enable = en; Shape = sh; MSB = m; Flash = f;
        WrEn = we; WrAddr = wa; WrData = wd;
        if (we && wa < 3'd7) pal[wa] = wd;
        ph = ((((ecount + 1) / BDIV) % 2) == 1);
        n.v = en;
        if (en) begin
            if (!m)              n.c = 3'b000;
            else if (sh >= 3'd7) n.c = 3'b000;
            else if (f && ph)    n.c = 3'b111;
            else                 n.c = pal[sh];
            last_c = n.c;
        end else begin
            n.c = last_c;
        end
        sbq.push_back(n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Resetn = 0; Enable = 0; Shape = 0; MSB = 0; Flash = 0;
        WrEn = 0; WrAddr = 0; WrData = 0;
        model_reset();
        #12;
        chk("rst_color", {5'b0, Color}, 8'h00);
        chk("rst_valid", {7'b0, ColorValid}, 8'h00);
        @(negedge Clock);
        Resetn = 1;

        // Default palette, back-to-back
        for (int i = 0; i < 7; i++) step(1, 3'(i), 1, 0, 0, 0, 0);
        idle(2);

        // Gating: empty cell, nonexistent shape, idle hold
        step(1, 3'd2, 0, 0, 0, 0, 0);
        step(1, 3'd7, 1, 0, 0, 0, 0);
        step(1, 3'd5, 1, 0, 0, 0, 0);
        idle(5);

        // Palette writes, including an ignored out-of-range address
        step(0, 0, 0, 0, 1, 3'd2, 3'b101);
        step(1, 3'd2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3'd7, 3'b110);
        step(1, 3'd7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 3'(i), 1, 0, 0, 0, 0);
        idle(2);

        // Write collision: old value out, new value on the next lookup
        step(1, 3'd3, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3'd3, 3'b111);
        step(1, 3'd3, 1, 0, 0, 0, 0);
        idle(2);

        // Blink: T piece flashing, then flashing empty cells
        for (int i = 0; i < 16; i++) step(1, 3'd4, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++)  step(1, 3'd4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)  step(1, 3'(i % 7), 1, (i % 2) == 1, (i == 3), 3'd1, 3'b000);
        idle(2);

        // Async reset mid-stream
        step(1, 3'd1, 1, 0, 0, 0, 0);
        step(1, 3'd6, 1, 0, 0, 0, 0);
        #2;
        Resetn = 0; Enable = 0; WrEn = 0;
        #1;
        chk("arst_color", {5'b0, Color}, 8'h00);
        chk("arst_valid", {7'b0, ColorValid}, 8'h00);
        model_reset();
        @(negedge Clock);
        Resetn = 1;
        step(1, 3'd2, 1, 0, 0, 0, 0);
        step(1, 3'd3, 1, 0, 0, 0, 0);
        step(1, 3'd1, 1, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 8; i++) step(1, 3'd4, 1, 1, 0, 0, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/piece_color_pipe.md
Name: piece_color_pipe

Overview:
Parametrised successor to the board colour lookup. It maps a piece shape index and an occupancy bit to a pixel colour. The palette is run-time programmable with reset defaults. A free-running blink timer flashes cells in rows being cleared. It sits between the board-memory readout and the VGA pixel writer as a 2-stage pipeline with a valid flag.

Parameters:
SHAPE_W, 3, width of shape index.
COLOR_W, 3, width of colour word (bit order R,G,B for COLOR_W=3).
NUM_SHAPES, 7, number of valid palette entries (must be at most 2**SHAPE_W).
BLINK_DIV, 12500000, clock cycles per blink half-period (at least 2).

Ports:
Clock  in  1  system clock, all state on rising edge.
Resetn  in  1  asynchronous active-low reset.
Enable  in  1  input sample qualifier; 1 = Shape/MSB/Flash valid this cycle.
Shape  in  SHAPE_W  piece shape index.
MSB  in  1  cell-occupied bit; 0 = empty cell.
Flash  in  1  cell belongs to a row being cleared.
WrEn  in  1  palette write strobe.
WrAddr  in  SHAPE_W  palette entry to write.
WrData  in  COLOR_W  new palette colour.
Color  out  COLOR_W  looked-up pixel colour.
ColorValid  out  1  Color corresponds to an accepted sample.

Behaviour:
- Reset (Resetn=0, async): Color=0 and ColorValid=0.
  - Both pipeline stages are cleared: valid bits 0, data 0.
  - The blink counter is 0 and the blink phase is 0.
  - Palette entries load the defaults: 0:011 (I), 1:110 (O), 2:010 (S), 3:001 (J), 4:101 (T), 5:100 (Z), 6:111 (L).
  - For COLOR_W>3 the default is zero-extended. Entries with index NUM_SHAPES or higher do not exist and always read 0.
- Stage 1, edge t: registers Shape, MSB, Flash, and v1=Enable.
  - With Enable=0, only v1 is cleared. The data fields may hold any value.
- Stage 2, edge t+1: ColorValid<=v1. Color is updated only when v1=1 and holds otherwise. The colour rules, in priority order:
  - MSB=0 -> 0.
  - Shape>=NUM_SHAPES -> 0.
  - Flash=1 and blink phase=1 -> all-ones (white).
  - Otherwise -> palette[Shape].
- Latency: exactly 2 cycles from the Enable edge to ColorValid. Throughput is one sample per cycle. There is no backpressure and no stall.
- Blink phase: the counter runs freely from 0 to BLINK_DIV-1 and wraps to 0.
  - On the wrap edge the phase toggles.
  - Stage 2 uses the phase value present before that edge. It does not use the toggled value.
- Palette write: WrEn=1 and WrAddr<NUM_SHAPES updates palette[WrAddr] at the edge.
  - WrAddr>=NUM_SHAPES is ignored silently.
  - Writes are independent of Enable.
- Same-edge write and stage-2 read of the same entry: read-before-write. Color takes the old value, and the new value applies from the next edge.
- Reset mid-stream: in-flight samples are discarded. The palette reverts to the defaults, so writes made before reset are lost.
- Inputs are sampled only at clock edges. Color is fully registered, with no combinational path from the inputs.

Test Plan:
1. Defaults: after reset, Enable=1 with Shape=0..6 and MSB=1 on consecutive cycles -> ColorValid rises 2 cycles later; Color=011,110,010,001,101,100,111 back-to-back.
2. Gating: MSB=0 with Shape=2 -> Color=000. Shape=7 with MSB=1 -> 000. Enable=0 for 3 cycles -> ColorValid=0 for 3 cycles and Color holds its last value.
3. Palette write: WrEn, WrAddr=2, WrData=101, then a lookup of Shape 2 -> 101. Write to WrAddr=7 -> a later lookup of Shape 7 stays 000 and entries 0..6 are unchanged.
4. Write collision: WrEn at WrAddr=3 with data 111 on the same edge as stage 2 resolves Shape 3 -> that output is 001, and the next Shape 3 lookup gives 111.
5. Blink (BLINK_DIV=4): Flash=1, Shape=4, MSB=1 streamed continuously -> Color alternates between 4 cycles of 101 and 4 cycles of 111. Flash=1 with MSB=0 -> 000 in both phases.
6. Async reset: assert Resetn=0 mid-stream between edges -> Color=0 and ColorValid=0 immediately. After release, the first valid appears 2 cycles after the first Enable, and the palette is at its defaults.
